// File: rtl/boot_copy_ctrl.sv
// Boot controller: copies a boot-ROM image into SRAM out of reset and holds the CPU in reset
// until the copy completes; small CPU register file for mode, length, checksum and reset pulse.
module boot_copy_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BOOTROM_ADDR_W = 12,
  parameter int unsigned SRAM_ADDR_W    = 16,
  parameter int unsigned DEST_BASE      = 2**(SRAM_ADDR_W-2) - 2**(BOOTROM_ADDR_W-2),
  parameter bit          BOOT_DEFAULT   = 1'b1,
  parameter int unsigned PULSE_LEN      = 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        cpu_rst,
  output logic                        boot,
  input  logic                        cpu_valid,
  input  logic [1:0]                  cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  input  logic [DATA_W/8-1:0]         cpu_wstrb,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_ready,
  output logic                        bootrom_r_en,
  output logic [BOOTROM_ADDR_W-3:0]   bootrom_addr,
  input  logic [DATA_W-1:0]           bootrom_r_data,
  output logic                        sram_valid,
  output logic [SRAM_ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]           sram_wdata,
  output logic [DATA_W/8-1:0]         sram_wstrb,
  input  logic                        sram_ready
);

  localparam int unsigned ROM_WORDS = 2**(BOOTROM_ADDR_W-2);
  localparam int unsigned IDX_W     = BOOTROM_ADDR_W-2;
  localparam int unsigned LEN_W     = BOOTROM_ADDR_W-1;
  localparam int unsigned SWA_W     = SRAM_ADDR_W-2;
  localparam int unsigned STRB_W    = DATA_W/8;
  localparam int unsigned PCNT_W    = $clog2(PULSE_LEN+1);

  typedef enum logic [1:0] {StIdle, StRd, StCap, StWr} state_e;

  state_e              state_q;
  logic                start_q;
  logic [IDX_W-1:0]    idx_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   csum_q;
  logic                done_q;
  logic                boot_q;
  logic [PCNT_W-1:0]   pulse_cnt_q;
  logic                cpu_ready_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                rom_en_q;
  logic [IDX_W-1:0]    rom_addr_q;
  logic                sram_valid_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0]   sram_wdata_q;  // doubles as the capture buffer
  logic [STRB_W-1:0]   sram_wstrb_q;

  logic              busy;
  logic              wr_en;
  logic              ctrl_wr;
  logic              len_wr;
  logic              start_req;
  logic              last_word;
  logic [LEN_W-1:0]  len_clamped;
  logic [SWA_W-1:0]  dest_word;
  logic [DATA_W-1:0] rd_data;

  assign busy      = (state_q != StIdle) | start_q;
  assign wr_en     = cpu_valid & (|cpu_wstrb);
  assign ctrl_wr   = wr_en & (cpu_addr == 2'd0) & ~busy;
  assign len_wr    = wr_en & (cpu_addr == 2'd1) & ~busy;
  assign start_req = ctrl_wr & cpu_wdata[2] & cpu_wdata[0];
  assign last_word = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
  assign dest_word = SWA_W'(DEST_BASE) + SWA_W'(idx_q);

  always_comb begin
    len_clamped = LEN_W'(cpu_wdata);
    if (cpu_wdata == '0 || cpu_wdata > DATA_W'(ROM_WORDS)) begin
      len_clamped = LEN_W'(ROM_WORDS);
    end
  end

  always_comb begin
    rd_data = '0;
    case (cpu_addr)
      2'd0: rd_data = DATA_W'({busy, boot_q});
      2'd1: rd_data = DATA_W'(len_q);
      2'd2: rd_data = csum_q;
      2'd3: rd_data = DATA_W'({boot_q, done_q, busy});
      default: rd_data = '0;
    endcase
  end

  // Copy FSM with registered ROM/SRAM outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      start_q      <= BOOT_DEFAULT;
      idx_q        <= '0;
      csum_q       <= '0;
      done_q       <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      sram_valid_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_wstrb_q <= '0;
    end else begin
      if (start_req) begin
        start_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (start_q) begin
            state_q    <= StRd;
            start_q    <= 1'b0;
            idx_q      <= '0;
            csum_q     <= '0;
            done_q     <= 1'b0;
            rom_en_q   <= 1'b1;
            rom_addr_q <= '0;
          end
        end
        StRd: begin
          state_q  <= StCap;
          rom_en_q <= 1'b0;
        end
        StCap: begin
          state_q      <= StWr;
          sram_wdata_q <= bootrom_r_data;
          sram_valid_q <= 1'b1;
          sram_addr_q  <= {dest_word, 2'b00};
          sram_wstrb_q <= '1;
        end
        StWr: begin
          if (sram_ready) begin
            csum_q       <= csum_q + sram_wdata_q;
            sram_valid_q <= 1'b0;
            sram_wstrb_q <= '0;
            if (last_word) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StRd;
              idx_q      <= idx_q + IDX_W'(1);
              rom_en_q   <= 1'b1;
              rom_addr_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // CPU register file and reset-pulse counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_q      <= BOOT_DEFAULT;
      len_q       <= LEN_W'(ROM_WORDS);
      pulse_cnt_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_ready_q <= cpu_valid;
      if (cpu_valid) begin
        cpu_rdata_q <= rd_data;
      end
      if (ctrl_wr) begin
        boot_q <= cpu_wdata[0];
      end
      if (len_wr) begin
        len_q <= len_clamped;
      end
      if (ctrl_wr && cpu_wdata[1]) begin
        pulse_cnt_q <= PCNT_W'(PULSE_LEN);
      end else if (pulse_cnt_q != '0) begin
        pulse_cnt_q <= pulse_cnt_q - PCNT_W'(1);
      end
    end
  end

  assign cpu_rst      = busy | (pulse_cnt_q != '0);
  assign boot         = boot_q;
  assign cpu_ready    = cpu_ready_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign bootrom_r_en = rom_en_q;
  assign bootrom_addr = rom_addr_q;
  assign sram_valid   = sram_valid_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;
  assign sram_wstrb   = sram_wstrb_q;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Bench for boot_copy_ctrl: ROM model, randomized SRAM backpressure and a word-list reference
// model for addresses, data, checksum and cpu_rst timing.
module tb_boot_copy_ctrl;

  localparam int DW   = 32;
  localparam int RAW  = 6;
  localparam int SAW  = 8;
  localparam int DB   = 48;
  localparam int PL   = 100;
  localparam int ROMW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cpu_rst;
  logic            boot;
  logic            cpu_valid = 1'b0;
  logic [1:0]      cpu_addr = 2'd0;
  logic [DW-1:0]   cpu_wdata = '0;
  logic [DW/8-1:0] cpu_wstrb = '0;
  logic [DW-1:0]   cpu_rdata;
  logic            cpu_ready;
  logic            bootrom_r_en;
  logic [RAW-3:0]  bootrom_addr;
  logic [DW-1:0]   rom_q = '0;
  logic            sram_valid;
  logic [SAW-1:0]  sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [DW/8-1:0] sram_wstrb;
  logic            sram_ready = 1'b1;

  logic [DW-1:0]   rom [ROMW];
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (bootrom_r_en) rom_q <= rom[bootrom_addr];

  boot_copy_ctrl #(
    .DATA_W(DW), .BOOTROM_ADDR_W(RAW), .SRAM_ADDR_W(SAW), .DEST_BASE(DB),
    .BOOT_DEFAULT(1'b1), .PULSE_LEN(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_rst(cpu_rst), .boot(boot),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .bootrom_r_en(bootrom_r_en), .bootrom_addr(bootrom_addr), .bootrom_r_data(rom_q),
    .sram_valid(sram_valid), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wstrb(sram_wstrb), .sram_ready(sram_ready)
  );

  function automatic logic [DW-1:0] model_sum(input int len);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < len; i++) s = s + rom[i];
    return s;
  endfunction

  task automatic fill_rom_default();
    for (int i = 0; i < ROMW; i++) rom[i] = 32'h100 + DW'(i);
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic cpu_write(input logic [1:0] a, input logic [DW-1:0] d);
    cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_wstrb = '1;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0; cpu_wstrb = '0;
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++; $display("FAIL wr_ready: got %b want 1", cpu_ready);
    end
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [DW-1:0] d);
    cpu_valid = 1'b1; cpu_addr = a; cpu_wstrb = '0;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
    d = cpu_rdata;
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++; $display("FAIL rd_ready: got %b want 1", cpu_ready);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; cpu_valid = 1'b0; sram_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one copy; the next rising edge is edge 1 of the copy. mode 0: ready high,
  // mode 1: stall word stall_word for stall_n cycles, mode 2: random ready.
  task automatic run_copy(input string name, input int len, input int mode,
                          input int stall_word, input int stall_n, output int stalls);
    int edge_n = 0;
    int got = 0;
    int fall = -1;
    int left = stall_n;
    logic [SAW-1:0] exp_a;
    logic [DW-1:0]  exp_d;
    stalls = 0;
    while (fall < 0 && edge_n < 1000) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      if (!cpu_rst) begin
        fall = edge_n;
      end else begin
        if (bootrom_r_en) begin
          total++;
          if (bootrom_addr !== 4'(got)) begin
            bad++; $display("FAIL %s rom_addr: got %0d want %0d", name, bootrom_addr, got);
          end
        end
        if (sram_valid) begin
          exp_a = 8'(((DB + got) % 64) * 4);
          exp_d = rom[got % ROMW];
          total++;
          if (sram_addr !== exp_a || sram_wdata !== exp_d || sram_wstrb !== 4'hF) begin
            bad++;
            $display("FAIL %s word %0d: got a=%h d=%h s=%h want a=%h d=%h s=f", name, got,
                     sram_addr, sram_wdata, sram_wstrb, exp_a, exp_d);
          end
          if (mode == 1 && got == stall_word && left > 0) begin
            sram_ready = 1'b0; left--;
          end else if (mode == 2) begin
            sram_ready = ($urandom_range(0, 2) != 0);
          end else begin
            sram_ready = 1'b1;
          end
          if (sram_ready) got++;
          else stalls++;
        end else begin
          sram_ready = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
      end
    end
    sram_ready = 1'b1;
    total++;
    if (fall != 3 * len + 1 + stalls) begin
      bad++; $display("FAIL %s rst_fall: got edge %0d want %0d", name, fall, 3*len+1+stalls);
    end
    total++;
    if (got != len) begin
      bad++; $display("FAIL %s nwrites: got %0d want %0d", name, got, len);
    end
    total++;
    if (sram_valid !== 1'b0) begin
      bad++; $display("FAIL %s valid_after: got %b want 0", name, sram_valid);
    end
  endtask

  task automatic test_reset();
    int st;
    logic [DW-1:0] d;
    fill_rom_default();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({cpu_rst, boot, cpu_ready, bootrom_r_en, sram_valid} !== 5'b11000) begin
      bad++; $display("FAIL reset_ctl: got %b want 11000",
                      {cpu_rst, boot, cpu_ready, bootrom_r_en, sram_valid});
    end
    total++;
    if ({cpu_rdata, bootrom_addr, sram_addr, sram_wdata, sram_wstrb} !== '0) begin
      bad++; $display("FAIL reset_data: got rd=%h ra=%h sa=%h wd=%h ws=%h want 0",
                      cpu_rdata, bootrom_addr, sram_addr, sram_wdata, sram_wstrb);
    end
    apply_reset();
    run_copy("boot", 16, 0, 0, 0, st);
    cpu_read(2'd2, d);
    total++;
    if (d !== model_sum(16)) begin
      bad++; $display("FAIL boot_csum: got %h want %h", d, model_sum(16));
    end
    cpu_read(2'd3, d);
    total++;
    if (d !== 32'h6) begin
      bad++; $display("FAIL boot_status: got %h want 6", d);
    end
    cpu_read(2'd1, d);
    total++;
    if (d !== 32'd16) begin
      bad++; $display("FAIL boot_len: got %0d want 16", d);
    end
  endtask

  task automatic test_backpressure();
    int st;
    apply_reset();
    run_copy("bp", 16, 1, 3, 5, st);
    total++;
    if (st != 5) begin
      bad++; $display("FAIL bp_stalls: got %0d want 5", st);
    end
  endtask

  task automatic test_reload_len();
    int st;
    logic [DW-1:0] d;
    cpu_write(2'd1, 32'd4);
    cpu_write(2'd0, 32'b101);
    total++;
    if (cpu_rst !== 1'b1) begin
      bad++; $display("FAIL reload_rst: got %b want 1", cpu_rst);
    end
    run_copy("reload", 4, 0, 0, 0, st);
    cpu_read(2'd2, d);
    total++;
    if (d !== model_sum(4)) begin
      bad++; $display("FAIL reload_csum: got %h want %h", d, model_sum(4));
    end
  endtask

  task automatic test_len_clamp();
    logic [DW-1:0] d;
    logic [DW-1:0] wv [3] = '{32'd0, 32'd40, 32'd7};
    logic [DW-1:0] ev [3] = '{32'd16, 32'd16, 32'd7};
    for (int i = 0; i < 3; i++) begin
      cpu_write(2'd1, wv[i]);
      cpu_read(2'd1, d);
      total++;
      if (d !== ev[i]) begin
        bad++; $display("FAIL len_clamp(%0d): got %0d want %0d", wv[i], d, ev[i]);
      end
    end
    cpu_write(2'd1, 32'd16);
  endtask

  task automatic test_reload_no_boot();
    logic [DW-1:0] d;
    cpu_write(2'd0, 32'b100);
    total++;
    if (cpu_rst !== 1'b0 || boot !== 1'b0) begin
      bad++; $display("FAIL noboot_rst: got rst=%b boot=%b want 0 0", cpu_rst, boot);
    end
    cpu_read(2'd3, d);
    total++;
    if (d !== 32'h2) begin
      bad++; $display("FAIL noboot_status: got %h want 2", d);
    end
  endtask

  task automatic test_reset_pulse();
    int cnt = 0;
    int early = 0;
    cpu_write(2'd0, 32'b010);
    while (cpu_rst && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    total++;
    if (cnt != PL) begin
      bad++; $display("FAIL pulse_len: got %0d want %0d", cnt, PL);
    end
    cpu_write(2'd0, 32'b010);
    for (int i = 0; i < 59; i++) begin
      if (!cpu_rst) early++;
      @(negedge clk);
    end
    cpu_write(2'd0, 32'b010);
    cnt = 0;
    while (cpu_rst && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    total++;
    if (early != 0 || cnt != PL) begin
      bad++; $display("FAIL pulse_extend: got early_low=%0d tail=%0d want 0 %0d", early, cnt, PL);
    end
  endtask

  task automatic test_random();
    int st;
    int len;
    logic [DW-1:0] d;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < ROMW; i++) rom[i] = $urandom;
      len = $urandom_range(1, 16);
      cpu_write(2'd1, DW'(len));
      cpu_write(2'd0, 32'b101);
      run_copy("rand", len, 2, 0, 0, st);
      cpu_read(2'd2, d);
      total++;
      if (d !== model_sum(len)) begin
        bad++; $display("FAIL rand_csum len=%0d: got %h want %h", len, d, model_sum(len));
      end
      cpu_read(2'd3, d);
      total++;
      if (d !== 32'h6) begin
        bad++; $display("FAIL rand_status: got %h want 6", d);
      end
    end
  endtask

  task automatic test_mid_copy_reset();
    int st;
    int n = 0;
    fill_rom_default();
    apply_reset();
    while (!(sram_valid && sram_addr == 8'((DB + 7) * 4)) && n < 200) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n >= 200) begin
      bad++; $display("FAIL mid_wait: got timeout want word 7 write");
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({cpu_rst, boot, cpu_ready, bootrom_r_en, sram_valid} !== 5'b11000 ||
        {cpu_rdata, bootrom_addr, sram_addr, sram_wdata, sram_wstrb} !== '0) begin
      bad++; $display("FAIL mid_reset_vals: got ctl=%b sa=%h wd=%h want 11000 0 0",
                      {cpu_rst, boot, cpu_ready, bootrom_r_en, sram_valid}, sram_addr, sram_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_copy("mid_restart", 16, 0, 0, 0, st);
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_reload_len();
    test_len_clamp();
    test_reload_no_boot();
    test_reset_pulse();
    test_random();
    test_mid_copy_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
